ysyx_23060203_idu_queue: RTL
============================

YSYX_23060203_IDU_QUEUE -- requirements
Module: ysyx_23060203_idu_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries; power of two, >= 2.
REQ-002 SHALL have parameter CW, default 2, width of each per-register pending counter; >= 1.
REQ-003 SHALL have port clock  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset: synchronous, active-high.
REQ-005 SHALL have port flush  input  1  pipeline flush from a later stage.
REQ-006 SHALL have port in_valid  input  1  upstream fetch entry valid.
REQ-007 SHALL have port in_ready  output  1  queue can accept an entry.
REQ-008 SHALL have port in_pc  input  32  fetched PC.
REQ-009 SHALL have port in_inst  input  32  fetched instruction.
REQ-010 SHALL have port out_valid  output  1  head entry is issuable downstream.
REQ-011 SHALL have port out_ready  input  1  downstream accepts.
REQ-012 SHALL have port out_pc  output  32  head PC.
REQ-013 SHALL have port out_inst  output  32  head instruction.
REQ-014 SHALL have port out_rd  output  5  head destination; 0 = no GPR write.
REQ-015 SHALL have port rel_valid  input  1  one issued writer releases its destination.
REQ-016 SHALL have port rel_rd  input  5  register being released.
REQ-017 SHALL have port stall_raw  output  1  head valid but blocked by the scoreboard.
REQ-018 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-019 SHALL implement a circular FIFO of DEPTH {pc, inst} entries with wrapping read/write pointers and an occupancy counter.
REQ-020 in_ready SHALL equal (count != DEPTH); it does not depend on out_ready, so there is no same-cycle pass-through when full.
REQ-021 Enqueue SHALL occur when in_valid & in_ready & ~flush; the entry is visible at the head no earlier than the next cycle (1-cycle minimum latency).
REQ-022 Decode of the head: opcode = inst[6:2]; rd = inst[11:7], forced to 0 for BRANCH (11000) and STORE (01000).
REQ-023 rs1 = inst[19:15] SHALL count as used except for LUI (01101), AUIPC (00101) and JAL (11011); rs2 = inst[24:20] SHALL count as used only for BRANCH, STORE and OP (01100); register x0 is never used.
REQ-024 The scoreboard SHALL hold 31 CW-bit counters (x1..x31), each giving the number of issued, unreleased writers of that register.
REQ-025 The head SHALL be hazarded if a used rs1 or rs2 has a nonzero counter, or if out_rd != 0 and its counter equals 2^CW-1 (saturation).
REQ-026 out_valid SHALL be count != 0 & ~hazard & ~flush.
REQ-027 stall_raw SHALL be count != 0 & hazard & ~flush.
REQ-028 Dequeue SHALL occur on out_valid & out_ready; a nonzero out_rd increments its counter at the same edge.
REQ-029 A release (rel_valid with rel_rd != 0) SHALL decrement counter[rel_rd] at the edge.
REQ-030 A release of a zero counter SHALL be ignored, with no underflow.
REQ-031 Issue and release of the same register in one cycle SHALL leave its counter unchanged.
REQ-032 A release SHALL NOT bypass combinationally: the hazard clears in the cycle after the release edge.
REQ-033 Simultaneous enqueue and dequeue SHALL leave count unchanged; both pointers advance.
REQ-034 flush SHALL, at the edge, empty the queue (pointers and count to 0), enqueue nothing and dequeue nothing.
REQ-035 flush SHALL NOT modify scoreboard counters; downstream SHALL issue a release for every issued writer, including killed ones.
REQ-036 out_pc, out_inst and out_rd are don't-care while count == 0.

Reset
REQ-037 While reset is high, the following SHALL hold at the edge: count = 0, pointers = 0, all counters = 0; therefore out_valid = 0, stall_raw = 0 and in_ready = 1 from the next cycle.
REQ-038 reset SHALL override flush, enqueue, dequeue and release in the same cycle.
REQ-039 A reset mid-operation SHALL discard all queued entries and pending counts.

Verification
REQ-040 Fill test, DEPTH=4, out_ready=0: push 5 entries back-to-back -> in_ready=0 after the 4th enqueue, count=4, 5th not accepted; then out_ready=1 -> entries pop in order with PCs 0x0,0x4,0x8,0xC.
REQ-041 RAW test: issue addi x5,x0,1, then add x6,x5,x5 at the head -> stall_raw=1, out_valid=0; rel_valid=1, rel_rd=5 in cycle N -> out_valid=1 in cycle N+1.
REQ-042 Saturation test, CW=2: issue three writers of x7 with no release -> 4th writer of x7 stalls; one release of x7 -> it issues the following cycle.
REQ-043 Flush test: flush asserted with count=3 and in_valid=1 -> count=0 next cycle and the incoming entry is dropped; counters are unchanged.
REQ-044 Release-underflow and simultaneity test: release x9 with counter 0 -> counter stays 0; issue writer of x3 while releasing x3 with counter=1 -> counter stays 1.
REQ-045 Reset test: assert reset with count=2 and counter[4]=1 -> next cycle count=0, out_valid=0, stall_raw=0, and a reader of x4 issues immediately after its enqueue latency.

Source files
------------

// File: rtl/ysyx_23060203_idu_queue.sv
// Decode-side instruction queue with a per-register pending-writer scoreboard.
// Entries are buffered in a circular FIFO; the head is decoded and is only
// offered downstream when none of its source registers has an in-flight
// writer and its destination counter still has headroom.
module ysyx_23060203_idu_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_pc,
    input  logic [31:0]              in_inst,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_inst,
    output logic [4:0]               out_rd,
    input  logic                     rel_valid,
    input  logic [4:0]               rel_rd,
    output logic                     stall_raw,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int            AW   = $clog2(DEPTH);
    localparam logic [AW:0]   FULL = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] SAT  = '1;

    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_OP     = 5'b01100;

    logic [31:0]   r_pc   [DEPTH];
    logic [31:0]   r_inst [DEPTH];
    logic [AW-1:0] r_rptr;
    logic [AW-1:0] r_wptr;
    logic [AW:0]   r_count;
    // Entry 0 is never written, so x0 always reads as "no pending writer".
    logic [CW-1:0] r_sb [32];

    logic [31:0] w_head_inst;
    logic [4:0]  w_op;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic        w_nonempty;
    logic        w_hazard;
    logic        w_enq;
    logic        w_deq;

    assign w_head_inst = r_inst[r_rptr];
    assign w_op        = w_head_inst[6:2];

    // Head decode; a source register of 0 means "not read".
    always_comb begin
        w_rd  = w_head_inst[11:7];
        w_rs1 = w_head_inst[19:15];
        w_rs2 = 5'd0;
        if (w_op == OP_BRANCH || w_op == OP_STORE)
            w_rd = 5'd0;
        if (w_op == OP_LUI || w_op == OP_AUIPC || w_op == OP_JAL)
            w_rs1 = 5'd0;
        if (w_op == OP_BRANCH || w_op == OP_STORE || w_op == OP_OP)
            w_rs2 = w_head_inst[24:20];
    end

    assign w_nonempty = (r_count != '0);
    assign w_hazard   = ((w_rs1 != 5'd0) && (r_sb[w_rs1] != '0)) ||
                        ((w_rs2 != 5'd0) && (r_sb[w_rs2] != '0)) ||
                        ((w_rd  != 5'd0) && (r_sb[w_rd]  == SAT));

    assign in_ready  = (r_count != FULL);
    assign out_valid = w_nonempty & ~w_hazard & ~flush;
    assign stall_raw = w_nonempty &  w_hazard & ~flush;
    assign out_pc    = r_pc[r_rptr];
    assign out_inst  = w_head_inst;
    assign out_rd    = w_rd;
    assign count     = r_count;

    assign w_enq = in_valid & in_ready & ~flush;
    assign w_deq = out_valid & out_ready;

    // Entry storage; stale slots are harmless because the pointers gate them.
    always_ff @(posedge clock) begin
        if (!reset && w_enq) begin
            r_pc[r_wptr]   <= in_pc;
            r_inst[r_wptr] <= in_inst;
        end
    end

    // Pointers and occupancy; flush empties the queue like a soft reset.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) r_wptr <= r_wptr + 1'b1;
            if (w_deq) r_rptr <= r_rptr + 1'b1;
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Scoreboard: issue increments, release decrements, both at once cancel.
    // Flush leaves it alone since killed writers are still released later.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) r_sb[i] <= '0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (w_deq && (w_rd == 5'(i)) && !(rel_valid && (rel_rd == 5'(i))))
                    r_sb[i] <= r_sb[i] + CW'(1);
                else if (rel_valid && (rel_rd == 5'(i)) && !(w_deq && (w_rd == 5'(i)))
                         && (r_sb[i] != '0))
                    r_sb[i] <= r_sb[i] - CW'(1);
            end
        end
    end
endmodule
